dmem_arbiter: RTL

Shares the single data-memory port between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA master). It sequences each access through an address/data phase, optional wait states, and a mandatory bus-turnaround cycle. Its memory-side outputs feed `dmem_interface`, which owns the tri-state pad; the arbiter itself never drives an inout.

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_if.sv | 32 +++
 rtl/dmem_arbiter_rr_arb2.sv | 31 +++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants and types for the data-memory arbiter
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    DARB_IDLE   = 2'd0,
    DARB_ACCESS = 2'd1,
    DARB_TURN   = 2'd2
  } darb_state_e;

  localparam int DARB_PORT_CPU = 0;
  localparam int DARB_PORT_DBG = 1;
  localparam int DARB_WAIT_W   = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    output done, rdata0, rdata1, busy, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  done, rdata0, rdata1, busy, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-input round-robin pick with last-grant flop
module dmem_arbiter_rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_o
);

  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt_o = last_gnt_q;
    case (req_i)
      2'b01:   gnt_o = 1'(DARB_PORT_CPU);
      2'b10:   gnt_o = 1'(DARB_PORT_DBG);
      2'b11:   gnt_o = ~last_gnt_q;
      default: gnt_o = last_gnt_q;
    endcase
    last_gnt_d = update_i ? gnt_o : last_gnt_q;
  end

  // Reset to the debug port so the CPU wins the first conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_gnt_q <= 1'(DARB_PORT_DBG);
    else         last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one data-memory port between CPU and debug requesters
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  dmem_arbiter_if.slave bus
);

  localparam logic [DARB_WAIT_W-1:0] WAIT_LD = DARB_WAIT_W'(WAIT_CYCLES);

  darb_state_e             state_q, state_d;
  logic [DARB_WAIT_W-1:0]  wait_q, wait_d;
  logic                    gnt_q, gnt_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                    mem_we_q, mem_we_d;
  logic [1:0]              done_q, done_d;
  logic [DATA_W-1:0]       rdata0_q, rdata0_d;
  logic [DATA_W-1:0]       rdata1_q, rdata1_d;
  logic                    arb_gnt;
  logic                    arb_update;

  assign arb_update = (state_q == DARB_IDLE) && (|bus.req);

  dmem_arbiter_rr_arb2 u_rr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (bus.req),
    .update_i (arb_update),
    .gnt_o    (arb_gnt)
  );

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    gnt_d       = gnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    done_d      = '0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      DARB_IDLE: begin
        if (|bus.req) begin
          gnt_d       = arb_gnt;
          mem_we_d    = bus.we[arb_gnt];
          mem_addr_d  = arb_gnt ? bus.addr1 : bus.addr0;
          mem_wdata_d = arb_gnt ? bus.wdata1 : bus.wdata0;
          wait_d      = WAIT_LD;
          state_d     = DARB_ACCESS;
        end
      end
      DARB_ACCESS: begin
        if (wait_q == '0) begin
          if (!mem_we_q) begin
            if (gnt_q) rdata1_d = bus.mem_rdata;
            else       rdata0_d = bus.mem_rdata;
          end
          done_d[gnt_q] = 1'b1;
          mem_we_d      = 1'b0;
          state_d       = DARB_TURN;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      // Turnaround: write enable already low, address held, requests ignored.
      DARB_TURN: state_d = DARB_IDLE;
      default:   state_d = DARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DARB_IDLE;
      wait_q      <= '0;
      gnt_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      done_q      <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      gnt_q       <= gnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign bus.done      = done_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = (state_q != DARB_IDLE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
